// File: rtl/gpio_ctrl_pkg.sv
// Shared register-map constants and helpers for the GPIO register block.
package gpio_ctrl_pkg;

  typedef logic [31:0] gpio_word_t;

  localparam logic [1:0] GPIO_OUT_OFS   = 2'd0;
  localparam logic [1:0] GPIO_OE_OFS    = 2'd1;
  localparam logic [1:0] GPIO_INCFG_OFS = 2'd2;
  localparam logic [1:0] GPIO_IRQ_OFS   = 2'd3;

  localparam int unsigned IRQ_EN_LSB = 16;

  function automatic gpio_word_t pack_word(input logic [15:0] hi, input logic [15:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/gpio_ctrl_if.sv
// Register-access port between the Wishbone slave (master side) and gpio_ctrl (slave side).
interface gpio_ctrl_if;
  logic        CTRL_WE;
  logic [3:0]  CTRL_ADDR;
  logic [31:0] CTRL_DATA_IN;
  logic [31:0] CTRL_DATA_OUT;

  modport master (
    output CTRL_WE, CTRL_ADDR, CTRL_DATA_IN,
    input  CTRL_DATA_OUT
  );

  modport slave (
    input  CTRL_WE, CTRL_ADDR, CTRL_DATA_IN,
    output CTRL_DATA_OUT
  );
endinterface

// File: rtl/gpio_ctrl_in_filter.sv
// Per-pin input path: two-flop synchroniser, optional debouncer, rising-edge detect.
// Debouncer present only when GPIO_DEBOUNCE_EN is defined.
module gpio_in_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic filt,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      prev  <= filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt;
  logic             filt_q;

  // Counter only runs while sync2 disagrees with the accepted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      filt_q <= 1'b0;
    end else if (sync2 == filt_q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt    <= '0;
      filt_q <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign filt = filt_q;
`else
  logic [CNT_W-1:0] unused_cfg;
  assign unused_cfg = CNT_W'(DEBOUNCE_CYCLES);
  assign filt       = sync2;
`endif

  assign rise = filt & ~prev;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO register block: OUT/OE/IN_CFG/IRQ_STAT registers, filtered inputs, level IRQ.
// Optional per-pin input debouncing via GPIO_DEBOUNCE_EN.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int unsigned NUM_GPIO        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 10
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  gpio_ctrl_if.slave          ctrl,
  input  logic [NUM_GPIO-1:0] GPIO_IN,
  output logic [NUM_GPIO-1:0] GPIO_OUT,
  output logic [NUM_GPIO-1:0] GPIO_OE,
  output logic                IRQ_O
);

  logic [NUM_GPIO-1:0] out_q;
  logic [NUM_GPIO-1:0] oe_q;
  logic [NUM_GPIO-1:0] irq_en_q;
  logic [NUM_GPIO-1:0] irq_stat_q;
  logic [NUM_GPIO-1:0] filt;
  logic [NUM_GPIO-1:0] rise;
  logic [NUM_GPIO-1:0] w1c;
  gpio_word_t          data_out_q;
  gpio_word_t          rd_data;
  logic                irq_q;
  logic                wr_out;
  logic                wr_oe;
  logic                wr_cfg;
  logic                wr_irq;
  logic [15:0]         out16;
  logic [15:0]         oe16;
  logic [15:0]         in16;
  logic [15:0]         en16;
  logic [15:0]         stat16;
  logic                unused_bits;

  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_pin
    gpio_in_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_filter (
      .clk   (CLK_I),
      .rst_n (RST_I),
      .pad   (GPIO_IN[g]),
      .filt  (filt[g]),
      .rise  (rise[g])
    );
  end

  always_comb begin
    wr_out = ctrl.CTRL_WE && (ctrl.CTRL_ADDR[3:2] == GPIO_OUT_OFS);
    wr_oe  = ctrl.CTRL_WE && (ctrl.CTRL_ADDR[3:2] == GPIO_OE_OFS);
    wr_cfg = ctrl.CTRL_WE && (ctrl.CTRL_ADDR[3:2] == GPIO_INCFG_OFS);
    wr_irq = ctrl.CTRL_WE && (ctrl.CTRL_ADDR[3:2] == GPIO_IRQ_OFS);
    w1c    = wr_irq ? ctrl.CTRL_DATA_IN[NUM_GPIO-1:0] : '0;
  end

  // Zero-extend each NUM_GPIO-wide register to its 16-bit field for readback.
  always_comb begin
    out16  = '0;
    oe16   = '0;
    in16   = '0;
    en16   = '0;
    stat16 = '0;
    out16[NUM_GPIO-1:0]  = out_q;
    oe16[NUM_GPIO-1:0]   = oe_q;
    in16[NUM_GPIO-1:0]   = filt;
    en16[NUM_GPIO-1:0]   = irq_en_q;
    stat16[NUM_GPIO-1:0] = irq_stat_q;
    rd_data = '0;
    case (ctrl.CTRL_ADDR[3:2])
      GPIO_OUT_OFS:   rd_data = pack_word(16'h0000, out16);
      GPIO_OE_OFS:    rd_data = pack_word(16'h0000, oe16);
      GPIO_INCFG_OFS: rd_data = pack_word(en16, in16);
      GPIO_IRQ_OFS:   rd_data = pack_word(16'h0000, stat16);
      default:        rd_data = '0;
    endcase
  end

  // A new edge setting a bit overrides a same-cycle W1C of that bit.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      out_q      <= '0;
      oe_q       <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      data_out_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_out) out_q    <= ctrl.CTRL_DATA_IN[NUM_GPIO-1:0];
      if (wr_oe)  oe_q     <= ctrl.CTRL_DATA_IN[NUM_GPIO-1:0];
      if (wr_cfg) irq_en_q <= ctrl.CTRL_DATA_IN[IRQ_EN_LSB +: NUM_GPIO];
      irq_stat_q <= (irq_stat_q & ~w1c) | (rise & irq_en_q);
      data_out_q <= rd_data;
      irq_q      <= |irq_stat_q;
    end
  end

  assign unused_bits        = ^{ctrl.CTRL_ADDR[1:0], ctrl.CTRL_DATA_IN};
  assign ctrl.CTRL_DATA_OUT = data_out_q;
  assign GPIO_OUT           = out_q;
  assign GPIO_OE            = oe_q;
  assign IRQ_O              = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed scoreboard bench for gpio_ctrl; debounce section used when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic        irq;
  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  gpio_ctrl_if bus ();

  always #5 clk = ~clk;

`ifdef GPIO_DEBOUNCE_EN
  gpio_ctrl #(.NUM_GPIO(16), .DEBOUNCE_CYCLES(8), .CNT_W(4)) dut (
`else
  gpio_ctrl #(.NUM_GPIO(16)) dut (
`endif
    .CLK_I    (clk),
    .RST_I    (rst_n),
    .ctrl     (bus),
    .GPIO_IN  (gpio_in),
    .GPIO_OUT (gpio_out),
    .GPIO_OE  (gpio_oe),
    .IRQ_O    (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_pop();
    exp_t x;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check(x.tag, bus.CTRL_DATA_OUT, x.exp);
    end
  endtask

  task automatic read(input logic [3:0] a, input logic [31:0] e, input string tag);
    bus.CTRL_ADDR = a;
    sb.push_back('{tag, e});
    tick();
    rd_pop();
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d);
    bus.CTRL_WE      = 1'b1;
    bus.CTRL_ADDR    = a;
    bus.CTRL_DATA_IN = d;
    tick();
    bus.CTRL_WE      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    gpio_in          = '0;
    bus.CTRL_WE      = 1'b0;
    bus.CTRL_ADDR    = '0;
    bus.CTRL_DATA_IN = '0;
    repeat (3) tick();
    check("rst_oe",   {16'h0, gpio_oe},  32'h0);
    check("rst_out",  {16'h0, gpio_out}, 32'h0);
    check("rst_irq",  {31'h0, irq},      32'h0);
    check("rst_dout", bus.CTRL_DATA_OUT, 32'h0);
    rst_n = 1'b1;
    read(4'h0, 32'h0, "rst_rd_out");
    read(4'h4, 32'h0, "rst_rd_oe");
    read(4'h8, 32'h0, "rst_rd_incfg");
    read(4'hC, 32'h0, "rst_rd_stat");

    write(4'h0, 32'h0000_A5A5);
    check("gpio_out_a5a5", {16'h0, gpio_out}, 32'h0000_A5A5);
    write(4'h4, 32'h0000_FFFF);
    check("gpio_oe_ffff", {16'h0, gpio_oe}, 32'h0000_FFFF);
    read(4'h0, 32'h0000_A5A5, "rd_out");
    read(4'h5, 32'h0000_FFFF, "rd_oe_low_addr_bits_ignored");

    bus.CTRL_WE      = 1'b1;
    bus.CTRL_ADDR    = 4'h0;
    bus.CTRL_DATA_IN = 32'h0000_1234;
    sb.push_back('{"rd_during_wr_old", 32'h0000_A5A5});
    tick();
    bus.CTRL_WE = 1'b0;
    rd_pop();
    read(4'h0, 32'h0000_1234, "rd_after_wr_new");

    write(4'h0, 32'hFFFF_0000);
    read(4'h0, 32'h0, "rd_out_upper_ignored");
    check("gpio_out_zero", {16'h0, gpio_out}, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    write(4'h8, 32'h0002_0000);
    gpio_in[1] = 1'b1;
    repeat (5) tick();
    gpio_in[1] = 1'b0;
    repeat (20) tick();
    read(4'h8, 32'h0002_0000, "glitch_in_blocked");
    read(4'hC, 32'h0, "glitch_no_stat");
    check("glitch_no_irq", {31'h0, irq}, 32'h0);
    gpio_in[1] = 1'b1;
    repeat (20) tick();
    read(4'h8, 32'h0002_0002, "pulse_in_accepted");
    read(4'hC, 32'h0000_0002, "pulse_stat");
    check("pulse_irq", {31'h0, irq}, 32'h1);
`else
    gpio_in[3] = 1'b1;
    read(4'h8, 32'h0, "in_lat_edge1");
    read(4'h8, 32'h0, "in_lat_edge2");
    read(4'h8, 32'h0000_0008, "in_lat_edge3");
    read(4'hC, 32'h0, "disabled_edge_no_stat");
    check("disabled_edge_no_irq", {31'h0, irq}, 32'h0);

    write(4'h8, 32'h0001_FFFF);
    read(4'h8, 32'h0001_0008, "incfg_in_read_only");

    gpio_in[0] = 1'b1;
    read(4'hC, 32'h0, "stat_lat_edge1");
    read(4'hC, 32'h0, "stat_lat_edge2");
    read(4'hC, 32'h0, "stat_lat_edge3");
    check("irq_not_yet", {31'h0, irq}, 32'h0);
    read(4'hC, 32'h0000_0001, "stat_set");
    check("irq_high", {31'h0, irq}, 32'h1);
    gpio_in[0] = 1'b0;
    write(4'hC, 32'h0000_0001);
    check("irq_lags_clear", {31'h0, irq}, 32'h1);
    read(4'hC, 32'h0, "w1c_cleared");
    check("irq_cleared", {31'h0, irq}, 32'h0);
    tick();

    gpio_in[0] = 1'b1;
    tick();
    tick();
    write(4'hC, 32'h0000_0001);
    read(4'hC, 32'h0000_0001, "set_beats_w1c");
    check("set_beats_w1c_irq", {31'h0, irq}, 32'h1);
    write(4'h8, 32'h0);
    read(4'hC, 32'h0000_0001, "pending_kept_after_disable");

    rst_n = 1'b0;
    #2;
    check("async_rst_irq",  {31'h0, irq},      32'h0);
    check("async_rst_oe",   {16'h0, gpio_oe},  32'h0);
    check("async_rst_dout", bus.CTRL_DATA_OUT, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    read(4'hC, 32'h0, "post_rst_no_stat");
    read(4'h8, 32'h0000_0009, "post_rst_in");
    check("post_rst_irq", {31'h0, irq}, 32'h0);
`endif

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
